// File: rtl/streamacc_pkg.sv
// streamacc_pkg: shared types, constants and helpers for the stream accumulator.
//   state_t  - top-level FSM states (ACCUM, SEND_SUM, SEND_STAT)
//   SAT_MAX / SAT_MIN - 32-bit signed saturation limits
//   sat32()  - clips a sign-extended accumulator value to 32 bits
//   sat_clips() - reports whether sat32() would clip
package streamacc_pkg;

    typedef enum logic [1:0] {
        ACCUM     = 2'd0,
        SEND_SUM  = 2'd1,
        SEND_STAT = 2'd2
    } state_t;

    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN = 32'h8000_0000;

    localparam logic signed [63:0] SAT_HI = 64'sd2147483647;
    localparam logic signed [63:0] SAT_LO = -64'sd2147483648;

    // Callers sign-extend the accumulator to 64 bits so one helper covers
    // every legal accumulator width.
    function automatic logic [31:0] sat32(input logic signed [63:0] acc);
        if (acc > SAT_HI) begin
            return SAT_MAX;
        end else if (acc < SAT_LO) begin
            return SAT_MIN;
        end else begin
            return acc[31:0];
        end
    endfunction

    function automatic logic sat_clips(input logic signed [63:0] acc);
        return (acc > SAT_HI) || (acc < SAT_LO);
    endfunction

endpackage

// File: rtl/streamacc_if.sv
// streamacc_if: 32-bit AXI4-Stream bundle.
//   tdata/tvalid/tlast flow from master to slave, tready flows back.
//   Handshake: a beat transfers on a rising clock edge where tvalid and
//   tready are both high; once tvalid is raised the master holds tdata,
//   tlast and tvalid stable until that transfer happens.
interface streamacc_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/streamacc_core.sv
// streamacc_core: accumulator, beat counter and sticky overflow flag.
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - return acc/cnt/ovf to zero (end of packet)
//   en          - accumulate din this cycle
//   sat_set     - force ovf (final sum clips when narrowed to 32 bits)
//   din         - 32-bit signed input beat
//   acc_nxt     - value acc takes at the next edge (used for the final sum)
//   cnt, ovf    - current beat count and overflow flag
module streamacc_core
    import streamacc_pkg::*;
#(
    parameter int ACC_W = 48,
    parameter int CNT_W = 31
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    sat_set,
    input  logic [31:0]             din,
    output logic signed [ACC_W-1:0] acc_nxt,
    output logic [CNT_W-1:0]        cnt,
    output logic                    ovf
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] din_ext;
    logic signed [ACC_W-1:0] sum;
    logic                    add_ovf;

    assign din_ext = ACC_W'($signed(din));
    assign sum     = acc + din_ext;
    // Signed overflow: operands share a sign that the result does not.
    assign add_ovf = (acc[ACC_W-1] == din_ext[ACC_W-1]) &&
                     (sum[ACC_W-1] != acc[ACC_W-1]);

    // On overflow the accumulator keeps its pre-add value.
    always_comb begin
        acc_nxt = acc;
        if (clr) begin
            acc_nxt = '0;
        end else if (en && !add_ovf) begin
            acc_nxt = sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            acc <= acc_nxt;
            if (clr) begin
                cnt <= '0;
                ovf <= 1'b0;
            end else begin
                if (en && (cnt != {CNT_W{1'b1}})) begin
                    cnt <= cnt + 1'b1;
                end
                ovf <= ovf | (en & add_ovf) | sat_set;
            end
        end
    end

endmodule

// File: rtl/streamacc_v1_0.sv
// streamacc_v1_0: AXI4-Stream packet accumulator.
//   s00_axis_aclk    - clock for both stream sides
//   s00_axis_aresetn - asynchronous active-low reset
//   s00_axis         - slave stream of 32-bit signed products, packets end on tlast
//   m00_axis         - master stream, two words per packet:
//                      saturated sum (tlast=0), then {ovf, cnt[30:0]} (tlast=1)
//   dbg_state        - current FSM state
module streamacc_v1_0
    import streamacc_pkg::*;
#(
    parameter int ACC_W = 48,
    parameter int CNT_W = 31
) (
    input  logic       s00_axis_aclk,
    input  logic       s00_axis_aresetn,
    streamacc_if.slave  s00_axis,
    streamacc_if.master m00_axis,
    output state_t     dbg_state
);

    state_t                  state;
    logic                    s_ready_q;
    logic                    m_valid_q;
    logic                    m_last_q;
    logic [31:0]             m_data_q;

    logic signed [ACC_W-1:0] acc_nxt;
    logic signed [63:0]      acc_wide;
    logic [CNT_W-1:0]        cnt;
    logic                    ovf;
    logic                    beat_ok;
    logic                    final_beat;
    logic                    m_hs;
    logic                    clr;
    logic                    sat_set;

    // s_ready_q is only ever high in ACCUM, so it alone qualifies a beat.
    assign beat_ok    = s_ready_q & s00_axis.tvalid;
    assign final_beat = beat_ok & s00_axis.tlast;
    assign m_hs       = m_valid_q & m00_axis.tready;
    assign clr        = (state == SEND_STAT) & m_hs;
    assign acc_wide   = 64'(acc_nxt);
    assign sat_set    = final_beat & sat_clips(acc_wide);

    streamacc_core #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_core (
        .clk     (s00_axis_aclk),
        .rst_n   (s00_axis_aresetn),
        .clr     (clr),
        .en      (beat_ok),
        .sat_set (sat_set),
        .din     (s00_axis.tdata),
        .acc_nxt (acc_nxt),
        .cnt     (cnt),
        .ovf     (ovf)
    );

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state     <= ACCUM;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    s_ready_q <= 1'b1;
                    if (final_beat) begin
                        // acc_nxt already includes the last beat.
                        state     <= SEND_SUM;
                        s_ready_q <= 1'b0;
                        m_valid_q <= 1'b1;
                        m_last_q  <= 1'b0;
                        m_data_q  <= sat32(acc_wide);
                    end
                end
                SEND_SUM: begin
                    if (m_hs) begin
                        state    <= SEND_STAT;
                        m_last_q <= 1'b1;
                        m_data_q <= {ovf, cnt[30:0]};
                    end
                end
                SEND_STAT: begin
                    if (m_hs) begin
                        state     <= ACCUM;
                        s_ready_q <= 1'b1;
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                        m_data_q  <= '0;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

    assign s00_axis.tready = s_ready_q;
    assign m00_axis.tvalid = m_valid_q;
    assign m00_axis.tlast  = m_last_q;
    assign m00_axis.tdata  = m_data_q;
    assign dbg_state       = state;

endmodule

// File: tb/tb_streamacc_v1_0.sv
// tb_streamacc_v1_0: self-checking bench for streamacc_v1_0.
//   Drives product beats on s00, models the expected output words in a
//   queue, and compares every m00 handshake against the queue head.
module tb_streamacc_v1_0;
    import streamacc_pkg::*;

    localparam int     TIMEOUT = 1000;
    localparam longint ACC_MAX = 64'sd140737488355327;   // 2^47-1
    localparam longint ACC_MIN = -64'sd140737488355328;  // -2^47
    localparam longint CNT_MAX = 64'sd2147483647;

    // ---------------- clock / reset ----------------
    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;

    always #5 clk = ~clk;

    streamacc_if s_if ();
    streamacc_if m_if ();

    streamacc_v1_0 #(
        .ACC_W (48),
        .CNT_W (31)
    ) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis         (s_if),
        .m00_axis         (m_if),
        .dbg_state        (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          checks     = 0;
    int          errors     = 0;
    logic [32:0] exp_q[$];          // {tlast, tdata}
    int          ready_mode = 0;    // 0: always ready, 1: random, 2: stalled
    int          gap_max    = 0;

    longint      m_acc = 0;
    longint      m_cnt = 0;
    logic        m_ovf = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    // Reference model of one accepted beat; on tlast it pushes both words.
    task automatic model_beat(input logic [31:0] d, input logic last);
        longint      s;
        logic [31:0] w;
        s = m_acc + longint'($signed(d));
        if (s > ACC_MAX || s < ACC_MIN) m_ovf = 1'b1;
        else                            m_acc = s;
        if (m_cnt < CNT_MAX) m_cnt++;
        if (last) begin
            if (m_acc > 64'sd2147483647) begin
                w = 32'h7FFF_FFFF;
                m_ovf = 1'b1;
            end else if (m_acc < -64'sd2147483648) begin
                w = 32'h8000_0000;
                m_ovf = 1'b1;
            end else begin
                w = m_acc[31:0];
            end
            exp_q.push_back({1'b0, w});
            exp_q.push_back({1'b1, m_ovf, m_cnt[30:0]});
            model_clear();
        end
    endtask

    // ---------------- driver tasks (entered on a negedge) ----------------
    task automatic send_beat(input logic [31:0] d, input logic last);
        int n;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = last;
        n = 0;
        while (!s_if.tready && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (n >= TIMEOUT) begin
            check("s_accept_timeout", 64'(n), 64'd0);
        end else begin
            // Accepted on the coming posedge; model it now so the expected
            // words are queued before the DUT can present them.
            model_beat(d, last);
        end
        @(negedge clk);
        s_if.tvalid = 1'b0;
        s_if.tdata  = 'x;
        s_if.tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5 * TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- output sink / monitor ----------------
    initial begin
        logic [32:0] e;
        m_if.tready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = 1'($urandom_range(0, 1));
                default: m_if.tready = 1'b0;
            endcase
            if (rst_n && m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    check("m_extra_word", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("m_word", 64'({m_if.tlast, m_if.tdata}), 64'(e));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_s_tready", 64'(s_if.tready), 64'd0);
        check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_m_tlast",  64'(m_if.tlast),  64'd0);
        check("rst_m_tdata",  64'(m_if.tdata),  64'd0);
        check("rst_state",    64'(dbg_state),   64'(ACCUM));
        rst_n = 1'b1;
        @(negedge clk);
        check("s_tready_after_rst", 64'(s_if.tready), 64'd1);

        // Small sums: 0+1+4+9 = 14, cnt 4.
        send_beat(32'd0, 1'b0);
        send_beat(32'd1, 1'b0);
        send_beat(32'd4, 1'b0);
        send_beat(32'd9, 1'b1);
        wait_drain();

        // Positive clip.
        send_beat(32'h7FFF_FFFF, 1'b0);
        send_beat(32'h7FFF_FFFF, 1'b1);
        wait_drain();

        // Negative clip, then a clean single-beat packet.
        send_beat(32'h8000_0000, 1'b0);
        send_beat(32'hFFFF_FFFF, 1'b1);
        send_beat(32'd5, 1'b1);
        wait_drain();

        // Output back-pressure: sum word must hold for 10 cycles.
        ready_mode = 2;
        send_beat(32'd1, 1'b0);
        send_beat(32'd2, 1'b0);
        send_beat(32'd3, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check("hold_m_tvalid", 64'(m_if.tvalid), 64'd1);
            check("hold_m_tdata",  64'(m_if.tdata),  64'd6);
            check("hold_m_tlast",  64'(m_if.tlast),  64'd0);
            check("hold_s_tready", 64'(s_if.tready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 ready_mode = 0;
        @(posedge clk);   // sum word handshake
        #1;
        check("stat_next_tvalid", 64'(m_if.tvalid), 64'd1);
        check("stat_next_tlast",  64'(m_if.tlast),  64'd1);
        check("stat_next_tdata",  64'(m_if.tdata),  64'h0000_0003);
        wait_drain();
        @(negedge clk);

        // Reset mid-packet: partial state must vanish.
        send_beat(32'd3, 1'b0);
        send_beat(32'd3, 1'b0);
        rst_n = 1'b0;
        model_clear();
        #1;
        check("midrst_s_tready", 64'(s_if.tready), 64'd0);
        check("midrst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("midrst_state",    64'(dbg_state),   64'(ACCUM));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_beat(32'd7, 1'b1);
        wait_drain();

        // Long packet of squares with random valid gaps and random ready.
        gap_max    = 2;
        ready_mode = 1;
        for (int i = 0; i < 10000; i++) begin
            send_beat(32'(i * i), (i == 9999) ? 1'b1 : 1'b0);
        end
        wait_drain();
        ready_mode = 0;
        repeat (5) @(negedge clk);
        check("end_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("end_queue",    64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
